// File: rtl/cond_exec_e.sv
// Execute-stage condition check for an ARM-style pipeline: evaluates CondE against the
// architectural flags, gates the flag write-back and registers the E/M control bits.
module cond_exec_e (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       flush,
   input  logic       PcsrcE,
   input  logic       RegWriteE,
   input  logic       MemtoRegE,
   input  logic       MemWriteE,
   input  logic       BranchE,
   input  logic [1:0] FlagWriteE,
   input  logic [3:0] CondE,
   input  logic [3:0] ALUFlags,
   output logic [3:0] Flags,
   output logic       CondExE,
   output logic       BranchTakenE,
   output logic       PCSrcM,
   output logic       RegWriteM,
   output logic       MemtoRegM,
   output logic       MemWriteM
);

   logic flag_n, flag_z, flag_c, flag_v;
   logic ge;

   assign {flag_n, flag_z, flag_c, flag_v} = Flags;
   assign ge = (flag_n == flag_v);

   // Evaluated on the registered flags only; ALUFlags of this cycle never bypass in.
   always_comb begin
      CondExE = 1'b0;
      case (CondE)
         4'b0000: CondExE = flag_z;
         4'b0001: CondExE = ~flag_z;
         4'b0010: CondExE = flag_c;
         4'b0011: CondExE = ~flag_c;
         4'b0100: CondExE = flag_n;
         4'b0101: CondExE = ~flag_n;
         4'b0110: CondExE = flag_v;
         4'b0111: CondExE = ~flag_v;
         4'b1000: CondExE = flag_c & ~flag_z;
         4'b1001: CondExE = ~flag_c | flag_z;
         4'b1010: CondExE = ge;
         4'b1011: CondExE = ~ge;
         4'b1100: CondExE = ~flag_z & ge;
         4'b1101: CondExE = flag_z | ~ge;
         4'b1110: CondExE = 1'b1;
         default: CondExE = 1'b0;
      endcase
   end

   assign BranchTakenE = BranchE & CondExE;

   // Flush clears only the control pipeline; the flags are architectural state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         Flags <= 4'b0000;
      end else if (en) begin
         if (FlagWriteE[1] & CondExE) Flags[3:2] <= ALUFlags[3:2];
         if (FlagWriteE[0] & CondExE) Flags[1:0] <= ALUFlags[1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         PCSrcM    <= 1'b0;
         RegWriteM <= 1'b0;
         MemtoRegM <= 1'b0;
         MemWriteM <= 1'b0;
      end else if (flush) begin
         PCSrcM    <= 1'b0;
         RegWriteM <= 1'b0;
         MemtoRegM <= 1'b0;
         MemWriteM <= 1'b0;
      end else if (en) begin
         PCSrcM    <= PcsrcE & CondExE;
         RegWriteM <= RegWriteE & CondExE;
         MemtoRegM <= MemtoRegE;
         MemWriteM <= MemWriteE & CondExE;
      end
   end

endmodule

// File: doc/cond_exec_e.md
COND_EXEC_E -- requirements
Module: cond_exec_e

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. Ports in order: clk in 1 (clock, rising edge); reset in 1 (async, active-low).
REQ-002 en  in  1  E/M register and flag-register update enable (1 = advance, 0 = hold).
REQ-003 flush  in  1  synchronous clear of the E/M control register.
REQ-004 PcsrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE  in  1 each  execute-stage control bits from the D/E control register.
REQ-005 FlagWriteE  in  2  flag-write request: bit1 = N,Z; bit0 = C,V.
REQ-006 CondE  in  4  ARM condition field of the execute-stage instruction.
REQ-007 ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
REQ-008 Flags  out  4  registered architectural flags {N,Z,C,V}, fed back to the D/E register.
REQ-009 CondExE  out  1  combinational: condition passed.
REQ-010 BranchTakenE  out  1  combinational: BranchE & CondExE.
REQ-011 PCSrcM, RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered E/M control bits.

Function
REQ-012 CondExE SHALL be evaluated against the current Flags register only, with no bypass from ALUFlags.
REQ-013 Condition table (N,Z,C,V = Flags[3:0]): 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0 (never).
REQ-014 On a rising edge with en=1: Flags[3:2] <= ALUFlags[3:2] iff FlagWriteE[1] & CondExE; Flags[1:0] <= ALUFlags[1:0] iff FlagWriteE[0] & CondExE; unselected halves hold.
REQ-015 With en=0, Flags SHALL hold regardless of FlagWriteE.
REQ-016 flush SHALL NOT affect Flags.
REQ-017 On a rising edge with flush=1: PCSrcM, RegWriteM, MemtoRegM, MemWriteM <= 0, regardless of en.
REQ-018 On a rising edge with flush=0 and en=1: PCSrcM <= PcsrcE & CondExE; RegWriteM <= RegWriteE & CondExE; MemWriteM <= MemWriteE & CondExE; MemtoRegM <= MemtoRegE (ungated).
REQ-019 On a rising edge with flush=0 and en=0, all E/M outputs SHALL hold.
REQ-020 Latency: a control bit presented in cycle n appears on the *M outputs after edge n+1. A flag update from cycle n is visible to CondExE in cycle n+1.
REQ-021 Back-to-back flag-setting instructions SHALL each see the flags left by the previous instruction; no cycle is lost.

Reset
REQ-022 While reset=0, asynchronously: Flags = 4'b0000 and PCSrcM = RegWriteM = MemtoRegM = MemWriteM = 0.
REQ-023 Reset asserted mid-operation SHALL override en and flush immediately. The first edge after release SHALL behave as a normal edge.
REQ-024 CondExE and BranchTakenE SHALL follow REQ-013 from the reset flags (e.g., EQ = 0, NE = 1).

Verification
REQ-025 Reset, then CondE=1110, RegWriteE=1, en=1 for one edge -> RegWriteM=1; Flags=0000.
REQ-026 CondE=1110, FlagWriteE=11, ALUFlags=0100, edge; then CondE=0000, BranchE=1 -> BranchTakenE=1; then CondE=0001 -> BranchTakenE=0.
REQ-027 Flags=0100; CondE=0001, FlagWriteE=11, MemWriteE=1, ALUFlags=1011, edge -> Flags stays 0100 and MemWriteM=0; MemtoRegM follows MemtoRegE.
REQ-028 Flags=0000; FlagWriteE=01, CondE=1110, ALUFlags=1111, edge -> Flags=0011. Then FlagWriteE=10, ALUFlags=1000, edge -> Flags=1011 (LT: CondExE=0 for N==V? N=1,V=1 -> LT false, GE true).
REQ-029 en=0, FlagWriteE=11, CondE=1110, ALUFlags=1111, RegWriteE=1 -> Flags and *M outputs hold. Same cycle with flush=1 -> *M outputs = 0, Flags unchanged.
REQ-030 Assert reset=0 between edges with PCSrcM=1, Flags=1111 -> both clear without a clock edge. Release, CondE=1111, PcsrcE=1, edge -> PCSrcM=0.
